// File: rtl/l2_tshr_update_scheduler.sv
// Arbitrates ALLOC/UPDATE/FREE requests onto the registered L2 TSHR update port.
// Define L2_TSHR_SCHED_AGING_EN to add per-requester starvation counters.
module l2_tshr_update_scheduler #(
  parameter int NUM_REQ       = 3,
  parameter int AGE_THRESHOLD = 8,
  parameter int IDX_W         = 3,
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 4,
  localparam int ENTRY_W      = 1 + ADDR_W + DATA_W
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             enable_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0][1:0]          req_op_i,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]    req_index_i,
  input  logic [NUM_REQ-1:0][ENTRY_W-1:0]  req_entry_i,
  output logic [NUM_REQ-1:0]               req_grant_o,
  output logic [IDX_W-1:0]                 alloc_index_o,
  input  logic                             tshr_full_i,
  input  logic [IDX_W-1:0]                 tshr_empty_index_i,
  output logic                             update_en_o,
  output logic [IDX_W-1:0]                 update_index_o,
  output logic [ENTRY_W-1:0]               update_entry_o
);

  localparam logic [1:0] OP_ALLOC  = 2'b01;
  localparam logic [1:0] OP_UPDATE = 2'b10;
  localparam logic [1:0] OP_FREE   = 2'b11;
  localparam logic [0:0] ST_READY  = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [0:0]         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               upd_en_q, upd_en_d;
  logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
  logic [ENTRY_W-1:0] upd_entry_q, upd_entry_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_vld;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  logic [1:0]         win_op;
  logic               is_alloc;

  function automatic logic [PTR_W-1:0] rr_add(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // ALLOC must wait out the bubble: tshr_empty_index does not yet reflect the last allocation.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = 1'b0;
      if (req_valid_i[k]) begin
        case (req_op_i[k])
          OP_UPDATE, OP_FREE: eligible[k] = 1'b1;
          OP_ALLOC:           eligible[k] = !tshr_full_i && (state_q == ST_READY);
          default:            eligible[k] = 1'b0;
        endcase
      end
    end
  end

`ifdef L2_TSHR_SCHED_AGING_EN
  localparam int AGE_W = $clog2(AGE_THRESHOLD + 1);
  logic [NUM_REQ-1:0][AGE_W-1:0] age_q, age_d;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      age_d[k] = age_q[k];
      if (grant[k]) age_d[k] = '0;
      else if (req_valid_i[k] && (age_q[k] != AGE_W'(AGE_THRESHOLD))) age_d[k] = age_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) age_q <= '0;
    else         age_q <= age_d;
  end
`endif

  always_comb begin
    grant_vld = 1'b0;
    win       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_add(rr_ptr_q, i);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        win       = cand;
      end
    end
`ifdef L2_TSHR_SCHED_AGING_EN
    // Descending scan so the lowest starved index ends up the winner.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[k] && (age_q[k] == AGE_W'(AGE_THRESHOLD))) begin
        grant_vld = 1'b1;
        win       = PTR_W'(k);
      end
    end
`endif
    if (!enable_i || reset_i) grant_vld = 1'b0;
  end

  always_comb begin
    grant = '0;
    if (grant_vld) grant[win] = 1'b1;
    win_op        = req_op_i[win];
    is_alloc      = grant_vld && (win_op == OP_ALLOC);
    alloc_index_o = is_alloc ? tshr_empty_index_i : '0;
  end

  always_comb begin
    upd_en_d    = upd_en_q;
    upd_idx_d   = upd_idx_q;
    upd_entry_d = upd_entry_q;
    if (grant_vld) begin
      upd_en_d = 1'b1;
      case (win_op)
        OP_ALLOC: begin
          upd_idx_d   = tshr_empty_index_i;
          upd_entry_d = {1'b1, req_entry_i[win][ENTRY_W-2:0]};
        end
        OP_FREE: begin
          upd_idx_d   = req_index_i[win];
          upd_entry_d = {1'b0, req_entry_i[win][ENTRY_W-2:DATA_W], DATA_W'(0)};
        end
        default: begin
          upd_idx_d   = req_index_i[win];
          upd_entry_d = req_entry_i[win];
        end
      endcase
    end else if (enable_i) begin
      upd_en_d = 1'b0;
    end

    state_d = state_q;
    if ((state_q == ST_BUBBLE) && enable_i) state_d = ST_READY;
    if (is_alloc) state_d = ST_BUBBLE;

    rr_ptr_d = grant_vld ? rr_add(win, 1) : rr_ptr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_READY;
      rr_ptr_q    <= '0;
      upd_en_q    <= 1'b0;
      upd_idx_q   <= '0;
      upd_entry_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      upd_en_q    <= upd_en_d;
      upd_idx_q   <= upd_idx_d;
      upd_entry_q <= upd_entry_d;
    end
  end

  assign req_grant_o    = grant;
  assign update_en_o    = upd_en_q;
  assign update_index_o = upd_idx_q;
  assign update_entry_o = upd_entry_q;

endmodule

// File: tb/tb_l2_tshr_update_scheduler.sv
// Directed bench for l2_tshr_update_scheduler: requester queues, a small TSHR table and a
// transaction-level scheduler model checked against the DUT every cycle.
module tb_l2_tshr_update_scheduler;
  localparam int N      = 3;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int EW     = 1 + ADDR_W + DATA_W;
  localparam int THR    = 2;
  localparam logic [1:0] ALLOC = 2'b01;
  localparam logic [1:0] UPD   = 2'b10;
  localparam logic [1:0] FREE  = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [IDX_W-1:0] idx;
    logic [EW-1:0]    ent;
  } req_t;

  logic clk = 1'b0;
  logic reset, enable;
  logic [N-1:0]            req_valid;
  logic [N-1:0][1:0]       req_op;
  logic [N-1:0][IDX_W-1:0] req_index;
  logic [N-1:0][EW-1:0]    req_entry;
  logic [N-1:0]            req_grant;
  logic [IDX_W-1:0]        alloc_index;
  logic                    tshr_full;
  logic [IDX_W-1:0]        tshr_empty_index;
  logic                    update_en;
  logic [IDX_W-1:0]        update_index;
  logic [EW-1:0]           update_entry;

  always #5 clk = ~clk;

  l2_tshr_update_scheduler #(
    .NUM_REQ(N), .AGE_THRESHOLD(THR), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_index_i(req_index), .req_entry_i(req_entry),
    .req_grant_o(req_grant), .alloc_index_o(alloc_index),
    .tshr_full_i(tshr_full), .tshr_empty_index_i(tshr_empty_index),
    .update_en_o(update_en), .update_index_o(update_index), .update_entry_o(update_entry)
  );

  req_t rq[N][$];
  logic tbl[8];
  logic force_full;

  int               m_rr;
  logic             m_bub, m_pend;
  logic [IDX_W-1:0] m_idx;
  logic [EW-1:0]    m_ent;
  int               m_age[N];

  logic [31:0] h_g[$], h_ue[$], h_idx[$], h_ent[$], h_ai[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [EW-1:0] mk(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {v, a, d};
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [1:0] op, input logic [IDX_W-1:0] idx, input logic [EW-1:0] ent);
    req_t r;
    r.op = op; r.idx = idx; r.ent = ent;
    rq[k].push_back(r);
  endtask

  task automatic hclr();
    h_g.delete(); h_ue.delete(); h_idx.delete(); h_ent.delete(); h_ai.delete();
  endtask

  task automatic drive();
    req_t r;
    int   e;
    logic found;
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        r = rq[k][0];
        req_valid[k] = 1'b1; req_op[k] = r.op; req_index[k] = r.idx; req_entry[k] = r.ent;
      end else begin
        req_valid[k] = 1'b0; req_op[k] = 2'b00; req_index[k] = '0; req_entry[k] = '0;
      end
    end
    e = 0; found = 1'b0;
    for (int t = 0; t < 8; t++) if (!found && !tbl[t]) begin e = t; found = 1'b1; end
    tshr_empty_index = IDX_W'(e);
    tshr_full = force_full || !found;
  endtask

  // Model: one transaction per cycle at most, decided from the scheduler's rules.
  task automatic check();
    int             win;
    logic [N-1:0]   elig, e_g;
    logic           e_al;
    logic [IDX_W-1:0] e_ai;
    req_t           r;
    if (reset) begin
      cmp("rst_grant", 32'(req_grant), 32'h0);
      cmp("rst_alloc_index", 32'(alloc_index), 32'h0);
      cmp("rst_update_en", 32'(update_en), 32'h0);
      cmp("rst_update_index", 32'(update_index), 32'h0);
      cmp("rst_update_entry", 32'(update_entry), 32'h0);
      m_rr = 0; m_bub = 1'b0; m_pend = 1'b0; m_idx = '0; m_ent = '0;
      for (int k = 0; k < N; k++) m_age[k] = 0;
      for (int t = 0; t < 8; t++) tbl[t] = 1'b0;
      h_g.push_back(0); h_ue.push_back(0); h_idx.push_back(0); h_ent.push_back(0); h_ai.push_back(0);
      return;
    end
    win = -1;
    for (int k = 0; k < N; k++)
      elig[k] = req_valid[k] && (req_op[k] == UPD || req_op[k] == FREE ||
                                 (req_op[k] == ALLOC && !tshr_full && !m_bub));
    if (enable) begin
`ifdef L2_TSHR_SCHED_AGING_EN
      for (int k = N - 1; k >= 0; k--) if (elig[k] && m_age[k] == THR) win = k;
`endif
      if (win < 0)
        for (int i = 0; i < N; i++) if (win < 0 && elig[(m_rr + i) % N]) win = (m_rr + i) % N;
    end
    e_g = '0; e_al = 1'b0; e_ai = '0;
    if (win >= 0) begin
      e_g[win] = 1'b1;
      e_al = (req_op[win] == ALLOC);
      if (e_al) e_ai = tshr_empty_index;
    end
    cmp("grant", 32'(req_grant), 32'(e_g));
    if (e_al) cmp("alloc_index", 32'(alloc_index), 32'(e_ai));
    cmp("update_en", 32'(update_en), 32'(m_pend));
    if (m_pend) begin
      cmp("update_index", 32'(update_index), 32'(m_idx));
      cmp("update_entry", 32'(update_entry), 32'(m_ent));
    end
    h_g.push_back(32'(e_g)); h_ue.push_back(32'(m_pend)); h_idx.push_back(32'(m_idx));
    h_ent.push_back(32'(m_ent)); h_ai.push_back(32'(e_ai));

    if (m_pend && enable) tbl[m_idx] = m_ent[EW-1];
    if (win >= 0) begin
      r = rq[win].pop_front();
      m_pend = 1'b1;
      case (r.op)
        ALLOC:   begin m_idx = tshr_empty_index; m_ent = {1'b1, r.ent[EW-2:0]}; end
        FREE:    begin m_idx = r.idx; m_ent = mk(1'b0, r.ent[EW-2 -: ADDR_W], '0); end
        default: begin m_idx = r.idx; m_ent = r.ent; end
      endcase
      m_rr = (win + 1) % N;
    end else if (enable) begin
      m_pend = 1'b0;
    end
    if (m_bub && enable) m_bub = 1'b0;
    if (e_al) m_bub = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k == win) m_age[k] = 0;
      else if (req_valid[k] && m_age[k] < THR) m_age[k]++;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) rq[k].delete();
    reset = 1'b1; enable = 1'b1; force_full = 1'b0;
    run(2);
    reset = 1'b0;
    hclr();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; force_full = 1'b0;
    for (int t = 0; t < 8; t++) tbl[t] = 1'b0;
    do_reset();

    // Single UPDATE from idle.
    run(2);
    hclr();
    push(0, UPD, 3'd2, mk(1'b1, 12'h123, 4'h7));
    run(3);
    cmp("t1_grant", h_g[0], 32'h1);
    cmp("t1_ue", h_ue[1], 32'h1);
    cmp("t1_idx", h_idx[1], 32'h2);
    cmp("t1_ent", h_ent[1], 32'(mk(1'b1, 12'h123, 4'h7)));
    cmp("t1_grant_after", h_g[1], 32'h0);

    // Back-to-back ALLOCs with the bubble.
    do_reset();
    push(0, ALLOC, 3'd7, mk(1'b0, 12'h0A0, 4'h1));
    push(1, ALLOC, 3'd6, mk(1'b0, 12'h0B0, 4'h2));
    run(4);
    cmp("t2_g0", h_g[0], 32'h1);
    cmp("t2_ai0", h_ai[0], 32'h0);
    cmp("t2_bubble", h_g[1], 32'h0);
    cmp("t2_g2", h_g[2], 32'h2);
    cmp("t2_ai2", h_ai[2], 32'h1);
    cmp("t2_ent1", h_ent[1], 32'(mk(1'b1, 12'h0A0, 4'h1)));
    cmp("t2_idx3", h_idx[3], 32'h1);

    // Round-robin rotation over a continuous UPDATE stream.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push(k, UPD, IDX_W'(k), mk(1'b1, 12'(12'h300 + k), 4'(k)));
    run(5);
    cmp("t3_g0", h_g[0], 32'h1);
    cmp("t3_g1", h_g[1], 32'h2);
    cmp("t3_g2", h_g[2], 32'h4);
    cmp("t3_g3", h_g[3], 32'h1);

    // ALLOC stalled by full TSHR.
    do_reset();
    force_full = 1'b1;
    push(2, ALLOC, 3'd0, mk(1'b0, 12'h444, 4'h5));
    run(5);
    force_full = 1'b0;
    run(2);
    cmp("t4_g0", h_g[0], 32'h0);
    cmp("t4_g4", h_g[4], 32'h0);
    cmp("t4_g5", h_g[5], 32'h4);
    cmp("t4_ent6", h_ent[6], 32'(mk(1'b1, 12'h444, 4'h5)));

    // Stall with a pending write.
    do_reset();
    push(0, UPD, 3'd3, mk(1'b1, 12'h555, 4'h3));
    push(1, UPD, 3'd4, mk(1'b1, 12'h666, 4'h4));
    run(1);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(2);
    cmp("t5_g0", h_g[0], 32'h1);
    cmp("t5_g2", h_g[2], 32'h0);
    cmp("t5_ue3", h_ue[3], 32'h1);
    cmp("t5_idx3", h_idx[3], 32'h3);
    cmp("t5_g4", h_g[4], 32'h2);
    cmp("t5_idx4", h_idx[4], 32'h3);
    cmp("t5_idx5", h_idx[5], 32'h4);

    // FREE clears valid and data; then reset drops a pending write.
    do_reset();
    push(1, FREE, 3'd5, mk(1'b1, 12'hABC, 4'hF));
    run(2);
    cmp("t6_g0", h_g[0], 32'h2);
    cmp("t6_idx1", h_idx[1], 32'h5);
    cmp("t6_ent1", h_ent[1], 32'(mk(1'b0, 12'hABC, 4'h0)));
    push(0, UPD, 3'd1, mk(1'b1, 12'h777, 4'h1));
    run(1);
    do_reset();
    run(1);
    cmp("t6_dropped", h_ue[0], 32'h0);

    // Starved ALLOC behind bubbles and an UPDATE stream.
    do_reset();
    push(0, ALLOC, 3'd0, mk(1'b0, 12'h800, 4'h8));
    push(1, ALLOC, 3'd0, mk(1'b0, 12'h900, 4'h9));
    for (int r = 0; r < 4; r++) begin
      push(0, UPD, 3'd6, mk(1'b1, 12'hA00, 4'(r)));
      push(2, UPD, 3'd7, mk(1'b1, 12'hB00, 4'(r)));
    end
    run(12);
    cmp("t7_g1", h_g[1], 32'h4);
`ifdef L2_TSHR_SCHED_AGING_EN
    cmp("t7_g2_aged", h_g[2], 32'h2);
`else
    cmp("t7_g2_rr", h_g[2], 32'h1);
    cmp("t7_g3_rr", h_g[3], 32'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/l2_tshr_update_scheduler.md
# l2_tshr_update_scheduler

Arbitrates allocate, update and free requests from several directory-controller requesters onto the single update port of the L2 TSHR. It hands out free TSHR slots and registers the winning write for one cycle before it reaches the table. Because the TSHR write is registered, a newly allocated slot is still reported as empty for one cycle, and the scheduler masks that window. Sits between the directory controller pipeline stages and the TSHR instance.

## Interface
- NUM_REQ, 3, number of requesters (≥2)
- AGE_THRESHOLD, 8, wait cycles before a requester escalates (used only with the aging feature)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global stall; also drives the TSHR enable
- req_valid  in  NUM_REQ  request pending per requester
- req_op  in  NUM_REQ×2  per requester: 01 ALLOC, 10 UPDATE, 11 FREE; 00 is illegal while valid
- req_index  in  NUM_REQ×tshr_idx_t  target slot for UPDATE/FREE; ignored for ALLOC
- req_entry  in  NUM_REQ×tshr_entry_t  entry to write; for FREE only the address is kept and valid is forced to 0
- req_grant  out  NUM_REQ  one-hot acceptance, same cycle as the request
- alloc_index  out  tshr_idx_t  slot assigned to an ALLOC; meaningful only with the granting cycle's req_grant
- tshr_full  in  1  TSHR full
- tshr_empty_index  in  tshr_idx_t  lowest empty TSHR slot
- update_en  out  1  TSHR write strobe
- update_index  out  tshr_idx_t  TSHR write slot
- update_entry  out  tshr_entry_t  TSHR write data

## Operation
- Valid/ready: a requester holds req_valid, req_op, req_index and req_entry stable until it sees req_grant. At most one grant per cycle.
- Eligibility of a request:
  - UPDATE and FREE: always eligible.
  - ALLOC: eligible only if !tshr_full and state==READY.
- Grants are issued only when both hold:
  - enable=1;
  - the output register is empty, or it is being consumed this cycle.
- Arbitration: round-robin over eligible requesters, starting at rr_ptr. On a grant to requester k, rr_ptr becomes (k+1) mod NUM_REQ.
- A granted ALLOC drives alloc_index=tshr_empty_index combinationally and loads the output register with update_entry=req_entry, valid forced to 1.
- A granted UPDATE or FREE loads req_index and req_entry into the output register (FREE with valid forced to 0).
- State machine:
  - READY → ALLOC_BUBBLE on an ALLOC grant.
  - ALLOC_BUBBLE → READY after one cycle in which enable=1.
  - While in ALLOC_BUBBLE, tshr_empty_index is stale and no ALLOC is granted; UPDATE and FREE may still be granted.
- Output register: update_en=1 is held, with its index and entry, until a cycle with enable=1 consumes it.
- Reset state: every output is 0, rr_ptr=0, state=READY, output register empty.
- Reset asserted mid-operation: any held write is dropped and no grant is issued.

## Timing
- Grant in cycle t → update_en=1 in t+1 (if enable=1 at t+1) → TSHR entry written at the end of t+1 → visible to TSHR lookups in t+2.
- Back-to-back ALLOCs are granted no closer than every 2 cycles. UPDATE/FREE sustain 1 per cycle.
- req_grant and alloc_index are combinational from requests, state, rr_ptr and the TSHR status inputs. All other outputs are registered.
- A FREE granted at t frees its slot in tshr_empty_index from t+2 onward.
- An ALLOC with tshr_full=1 waits; req_grant stays 0 and no state changes.

## Configuration
- L2_TSHR_SCHED_AGING_EN defined:
  - Each requester has a saturating wait counter, width $clog2(AGE_THRESHOLD+1).
  - The counter increments every cycle the requester has req_valid=1 without a grant, and clears on grant.
  - Eligible requesters whose counter equals AGE_THRESHOLD win over round-robin; among them the lowest index wins.
  - rr_ptr still updates on the grant.
- L2_TSHR_SCHED_AGING_EN undefined: no counters; pure round-robin.

## Test plan
- Reset, then idle → all outputs 0; req0 UPDATE index 2 at t → req_grant=001 at t; update_en=1, update_index=2 at t+1.
- req0 and req1 both ALLOC, tshr_empty_index=0, then 1 → req0 granted with alloc_index=0; t+1 bubble with no grant; req1 granted at t+2 with alloc_index=1.
- Three requesters issuing UPDATEs continuously → grants rotate 001, 010, 100, 001.
- tshr_full=1 with req2 ALLOC for 5 cycles → no grant; full drops → grant next cycle; update_entry.valid=1.
- enable=0 for 3 cycles with update_en pending → update_en held and no grants; enable=1 → write consumed, next grant proceeds.
- Aging build, AGE_THRESHOLD=2, req1 ALLOC blocked by bubbles while req0/req2 UPDATE stream → once counter=2 and the bubble ends, req1 granted ahead of rr_ptr.
